// File: rtl/lut_loader_pkg.sv
// Shared types and constants for the LUT page loader: FSM state encoding,
// default memory geometry and the checksum width helper.
package lut_loader_pkg;

   localparam int LUT_QUAN_SIZE     = 3;
   localparam int LUT_PAGE_NUM      = 16;
   localparam int LUT_ADDR_BITWIDTH = 4;

   // One bit wider than entry + address bits, so a sum of up to PAGE_NUM
   // entries can never wrap.
   function automatic int cksum_width(input int quan_size, input int addr_bitwidth);
      return quan_size + addr_bitwidth + 1;
   endfunction

   localparam int CKSUM_W = cksum_width(LUT_QUAN_SIZE, LUT_ADDR_BITWIDTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_VERIFY = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } loader_state_e;

endpackage

// File: rtl/lut_loader_cksum.sv
// Clearable running-sum accumulator; one instance sums written entries,
// another sums the values read back from the memory.
module lut_loader_cksum
   import lut_loader_pkg::*;
#(
   parameter int DATA_W = LUT_QUAN_SIZE,
   parameter int SUM_W  = CKSUM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [SUM_W-1:0]  sum_o
);

   logic [SUM_W-1:0] sum_d;
   logic [SUM_W-1:0] sum_q;

   // Next sum: clear has priority over accumulate.
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (en_i) begin
         sum_d = sum_q + {{(SUM_W-DATA_W){1'b0}}, data_i};
      end else begin
         sum_d = sum_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/lut_page_loader.sv
// Write-side sequencer for the single-port IB LUT memory. Accepts a load
// command plus a valid/ready entry stream, writes consecutive pages with
// wrap-around, and optionally reads them back to compare checksums.
module lut_page_loader
   import lut_loader_pkg::*;
#(
   parameter int QUAN_SIZE     = LUT_QUAN_SIZE,
   parameter int PAGE_NUM      = LUT_PAGE_NUM,
   parameter int ADDR_BITWIDTH = LUT_ADDR_BITWIDTH
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     start_i,
   input  logic [ADDR_BITWIDTH-1:0] base_addr_i,
   input  logic [ADDR_BITWIDTH:0]   page_cnt_i,
   input  logic                     verify_en_i,
   input  logic [QUAN_SIZE-1:0]     load_data_i,
   input  logic                     load_valid_i,
   output logic                     load_ready_o,
   output logic [QUAN_SIZE-1:0]     write_data_o,
   output logic [ADDR_BITWIDTH-1:0] access_addr_o,
   output logic                     we_o,
   input  logic [QUAN_SIZE-1:0]     read_page_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     error_o
);

   localparam int SUM_W = cksum_width(QUAN_SIZE, ADDR_BITWIDTH);
   localparam logic [ADDR_BITWIDTH:0] CNT_ONE  = {{ADDR_BITWIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_BITWIDTH:0] PAGE_LIM = (ADDR_BITWIDTH+1)'(PAGE_NUM);

   loader_state_e              state_d, state_q;
   logic [ADDR_BITWIDTH-1:0]   base_d, base_q;
   logic [ADDR_BITWIDTH:0]     cnt_d, cnt_q;
   logic [ADDR_BITWIDTH:0]     offset_d, offset_q;
   logic                       verify_d, verify_q;
   logic                       we_d, we_q;
   logic [ADDR_BITWIDTH-1:0]   addr_d, addr_q;
   logic [QUAN_SIZE-1:0]       wdata_d, wdata_q;
   logic                       busy_d, busy_q;
   logic                       done_d, done_q;
   logic                       error_d, error_q;
   logic                       rd_issue_d, rd_issue_q;
   logic                       rvalid_d, rvalid_q;

   logic                       handshake_s;
   logic                       last_s;
   logic                       cnt_legal_s;
   logic [ADDR_BITWIDTH:0]     addr_sum_s;
   logic [ADDR_BITWIDTH:0]     addr_wrap_s;
   logic [ADDR_BITWIDTH-1:0]   page_addr_s;
   logic                       sum_clr_s;
   logic [SUM_W-1:0]           wsum_s;
   logic [SUM_W-1:0]           rsum_s;
   logic [SUM_W-1:0]           rsum_final_s;
   logic                       mismatch_s;

   assign handshake_s = load_valid_i && (state_q == ST_WRITE);
   assign last_s      = (offset_q == (cnt_q - CNT_ONE));
   assign cnt_legal_s = (page_cnt_i != {(ADDR_BITWIDTH+1){1'b0}}) && (page_cnt_i <= PAGE_LIM);

   // Page address = (base + offset) mod PAGE_NUM; both terms are below
   // PAGE_NUM so a single conditional subtract is enough.
   always_comb begin
      addr_sum_s = {1'b0, base_q} + {1'b0, offset_q[ADDR_BITWIDTH-1:0]};
      if (addr_sum_s >= PAGE_LIM) begin
         addr_wrap_s = addr_sum_s - PAGE_LIM;
      end else begin
         addr_wrap_s = addr_sum_s;
      end
   end
   assign page_addr_s = addr_wrap_s[ADDR_BITWIDTH-1:0];

   // The last readback value arrives in the DONE cycle, so the comparison
   // folds it in directly instead of waiting for the accumulator.
   assign rsum_final_s = rsum_s + (rvalid_q ? {{(SUM_W-QUAN_SIZE){1'b0}}, read_page_i}
                                            : {SUM_W{1'b0}});
   assign mismatch_s   = (wsum_s != rsum_final_s);

   // Next-state and next-output logic for the command sequencer.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      offset_d   = offset_q;
      verify_d   = verify_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = error_q;
      rd_issue_d = 1'b0;
      rvalid_d   = rd_issue_q;
      sum_clr_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               base_d    = base_addr_i;
               cnt_d     = page_cnt_i;
               offset_d  = '0;
               sum_clr_s = 1'b1;
               busy_d    = 1'b1;
               if (cnt_legal_s) begin
                  verify_d = verify_en_i;
                  error_d  = 1'b0;
                  state_d  = ST_WRITE;
               end else begin
                  verify_d = 1'b0;
                  error_d  = 1'b1;
                  state_d  = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (handshake_s) begin
               we_d    = 1'b1;
               addr_d  = page_addr_s;
               wdata_d = load_data_i;
               if (last_s) begin
                  offset_d = '0;
                  state_d  = verify_q ? ST_VERIFY : ST_DONE;
               end else begin
                  offset_d = offset_q + CNT_ONE;
               end
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_VERIFY: begin
            addr_d     = page_addr_s;
            rd_issue_d = 1'b1;
            if (last_s) begin
               offset_d = '0;
               state_d  = ST_DRAIN;
            end else begin
               offset_d = offset_q + CNT_ONE;
            end
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (verify_q) begin
               error_d = error_q | mismatch_s;
            end else begin
               error_d = error_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         cnt_q      <= '0;
         offset_q   <= '0;
         verify_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         rd_issue_q <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         offset_q   <= offset_d;
         verify_q   <= verify_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         rd_issue_q <= rd_issue_d;
         rvalid_q   <= rvalid_d;
      end
   end

   lut_loader_cksum #(.DATA_W(QUAN_SIZE), .SUM_W(SUM_W)) u_wsum (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .clr_i  (sum_clr_s),
      .en_i   (handshake_s),
      .data_i (load_data_i),
      .sum_o  (wsum_s)
   );

   lut_loader_cksum #(.DATA_W(QUAN_SIZE), .SUM_W(SUM_W)) u_rsum (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .clr_i  (sum_clr_s),
      .en_i   (rvalid_q),
      .data_i (read_page_i),
      .sum_o  (rsum_s)
   );

   assign load_ready_o  = (state_q == ST_WRITE);
   assign we_o          = we_q;
   assign access_addr_o = addr_q;
   assign write_data_o  = wdata_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;

endmodule

// File: tb/tb_lut_page_loader.sv
// Bench for lut_page_loader: behavioural LUT memory, write monitor and a
// page-level reference model derived from the command rules.
module tb_lut_page_loader;

   localparam int Q = 3;
   localparam int P = 16;
   localparam int A = 4;

   logic         sys_clk = 1'b0;
   logic         sys_rst;
   logic         start_i;
   logic [A-1:0] base_addr_i;
   logic [A:0]   page_cnt_i;
   logic         verify_en_i;
   logic [Q-1:0] load_data_i;
   logic         load_valid_i;
   logic         load_ready_o;
   logic [Q-1:0] write_data_o;
   logic [A-1:0] access_addr_o;
   logic         we_o;
   logic [Q-1:0] read_page_i;
   logic         busy_o;
   logic         done_o;
   logic         error_o;

   always #5 sys_clk = ~sys_clk;

   lut_page_loader #(.QUAN_SIZE(Q), .PAGE_NUM(P), .ADDR_BITWIDTH(A)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .start_i       (start_i),
      .base_addr_i   (base_addr_i),
      .page_cnt_i    (page_cnt_i),
      .verify_en_i   (verify_en_i),
      .load_data_i   (load_data_i),
      .load_valid_i  (load_valid_i),
      .load_ready_o  (load_ready_o),
      .write_data_o  (write_data_o),
      .access_addr_o (access_addr_o),
      .we_o          (we_o),
      .read_page_i   (read_page_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o)
   );

   // Behavioural single-port memory with a registered read port.
   logic [Q-1:0] mem [P];
   logic [Q-1:0] rd_data;
   logic [A-1:0] rd_addr;
   logic         mem_clear;
   logic         corrupt_en;

   always @(posedge sys_clk) begin
      if (mem_clear) begin
         for (int i = 0; i < P; i++) mem[i] <= '0;
      end else if (we_o) begin
         mem[access_addr_o] <= write_data_o;
      end
      rd_data <= mem[access_addr_o];
      rd_addr <= access_addr_o;
   end
   assign read_page_i = (corrupt_en && rd_addr == 4'd3) ? ~rd_data : rd_data;

   // Cycle counter and event monitor.
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   logic [A-1:0] wr_addr_q [$];
   logic [Q-1:0] wr_data_q [$];
   int           hs_cyc [$];
   int           done_cnt = 0;
   int           done_cyc = 0;
   logic         err_at_done = 1'b0;
   logic         busy_at_done = 1'b0;

   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (we_o) begin
            wr_addr_q.push_back(access_addr_o);
            wr_data_q.push_back(write_data_o);
         end
         if (load_valid_i && load_ready_o) hs_cyc.push_back(cyc);
         if (done_o) begin
            done_cnt     = done_cnt + 1;
            done_cyc     = cyc;
            err_at_done  = error_o;
            busy_at_done = busy_o;
         end
      end
   end

   int           n_checks = 0;
   int           n_err = 0;
   logic [Q-1:0] ref_mem [P];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ready"}, 32'(load_ready_o), 32'd0);
      chk({tag, "_we"},    32'(we_o),         32'd0);
      chk({tag, "_busy"},  32'(busy_o),       32'd0);
      chk({tag, "_done"},  32'(done_o),       32'd0);
   endtask

   // One full command: drive it, feed beats, wait for done, compare against
   // the page-level model (addresses wrap mod P, data in stream order).
   task automatic run_cmd(input string tag, input int base, input int cnt, input bit ver,
                          input bit gaps, input bit busy_starts, input bit rnd_data,
                          input bit exp_err);
      logic [Q-1:0] beats [$];
      int  start_c, wr0, hs0, dn0, sent, guard, exp_wr, last_hs;
      bit  legal, hs;
      legal = (cnt >= 1) && (cnt <= P);
      for (int i = 0; i < cnt && i < P; i++) begin
         if (rnd_data) beats.push_back(Q'($urandom_range(0, 7)));
         else          beats.push_back(Q'(((base + i) % P) % 8));
      end
      wr0 = wr_addr_q.size();
      hs0 = hs_cyc.size();
      dn0 = done_cnt;

      @(posedge sys_clk); #1;
      start_i     = 1'b1;
      base_addr_i = A'(base);
      page_cnt_i  = (A+1)'(cnt);
      verify_en_i = ver;
      start_c     = cyc;
      @(posedge sys_clk); #1;
      start_i = 1'b0;
      chk({tag, "_busy_rise"}, 32'(busy_o), 32'd1);

      if (legal) begin
         sent  = 0;
         guard = 0;
         while (sent < cnt && guard < 400) begin
            load_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            load_data_i  = beats[sent];
            if (busy_starts) begin
               start_i     = 1'($urandom_range(0, 1));
               base_addr_i = A'($urandom_range(0, P-1));
               page_cnt_i  = 5'd2;
            end
            @(negedge sys_clk);
            hs = load_valid_i && load_ready_o;
            @(posedge sys_clk); #1;
            if (hs) sent++;
            guard++;
         end
         load_valid_i = 1'b0;
         start_i      = 1'b0;
         chk({tag, "_beats_taken"}, 32'(sent), 32'(cnt));
      end else if (busy_starts) begin
         start_i     = 1'b1;
         base_addr_i = 4'd0;
         page_cnt_i  = 5'd4;
         @(posedge sys_clk); #1;
         start_i = 1'b0;
      end

      guard = 0;
      while (done_cnt == dn0 && guard < 200) begin
         @(posedge sys_clk); #1;
         guard++;
      end
      repeat (3) @(posedge sys_clk);
      #1;
      chk({tag, "_done_pulses"}, 32'(done_cnt - dn0), 32'd1);
      chk({tag, "_error"},       32'(err_at_done),    32'(exp_err));
      chk({tag, "_busy_at_done"}, 32'(busy_at_done),  32'd0);
      chk({tag, "_err_held"},    32'(error_o),        32'(exp_err));
      check_idle_outputs({tag, "_after"});

      if (!legal) begin
         chk({tag, "_latency"}, 32'(done_cyc - start_c), 32'd2);
      end else if (!gaps) begin
         chk({tag, "_latency"}, 32'(done_cyc - start_c),
             32'(2 + cnt + (ver ? cnt + 1 : 0)));
      end else begin
         last_hs = hs_cyc[hs_cyc.size() - 1];
         chk({tag, "_tail_latency"}, 32'(done_cyc - last_hs), 32'(ver ? cnt + 3 : 2));
      end

      exp_wr = legal ? cnt : 0;
      chk({tag, "_handshakes"}, 32'(hs_cyc.size() - hs0), 32'(exp_wr));
      chk({tag, "_writes"},     32'(wr_addr_q.size() - wr0), 32'(exp_wr));
      if (wr_addr_q.size() - wr0 == exp_wr) begin
         for (int i = 0; i < exp_wr; i++) begin
            chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr_q[wr0 + i]), 32'((base + i) % P));
            chk($sformatf("%s_wr%0d_data", tag, i), 32'(wr_data_q[wr0 + i]), 32'(beats[i]));
         end
      end
      for (int i = 0; i < exp_wr; i++) ref_mem[(base + i) % P] = beats[i];
      for (int p = 0; p < P; p++) begin
         chk($sformatf("%s_mem%0d", tag, p), 32'(mem[p]), 32'(ref_mem[p]));
      end
   endtask

   initial begin
      logic [Q-1:0] rbeats [3];
      int           wr0, sent, guard;
      bit           hs;

      sys_rst      = 1'b1;
      mem_clear    = 1'b1;
      corrupt_en   = 1'b0;
      start_i      = 1'b0;
      base_addr_i  = '0;
      page_cnt_i   = '0;
      verify_en_i  = 1'b0;
      load_data_i  = '0;
      load_valid_i = 1'b0;
      for (int p = 0; p < P; p++) ref_mem[p] = '0;

      repeat (3) @(posedge sys_clk);
      #1;
      check_idle_outputs("reset");
      chk("reset_error", 32'(error_o),       32'd0);
      chk("reset_addr",  32'(access_addr_o), 32'd0);
      chk("reset_wdata", 32'(write_data_o),  32'd0);
      mem_clear = 1'b0;
      sys_rst   = 1'b0;

      run_cmd("full",    0, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("cnt0",    0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      run_cmd("cnt17",   3, 17, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      run_cmd("wrap",   14,  4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_cmd("gaps",   int'($urandom_range(0, P-1)), 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      corrupt_en = 1'b1;
      run_cmd("corrupt", 1,  5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      corrupt_en = 1'b0;

      // Reset in the middle of a write burst after three beats.
      for (int i = 0; i < 3; i++) rbeats[i] = Q'($urandom_range(0, 7));
      wr0 = wr_addr_q.size();
      @(posedge sys_clk); #1;
      start_i     = 1'b1;
      base_addr_i = 4'd0;
      page_cnt_i  = 5'd8;
      verify_en_i = 1'b1;
      @(posedge sys_clk); #1;
      start_i = 1'b0;
      sent  = 0;
      guard = 0;
      while (sent < 3 && guard < 20) begin
         load_valid_i = 1'b1;
         load_data_i  = rbeats[sent];
         @(negedge sys_clk);
         hs = load_valid_i && load_ready_o;
         @(posedge sys_clk); #1;
         if (hs) sent++;
         guard++;
      end
      load_valid_i = 1'b0;
      chk("rst_beats_taken", 32'(sent), 32'd3);
      @(posedge sys_clk); #2;
      sys_rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      chk("midrst_error", 32'(error_o),       32'd0);
      chk("midrst_addr",  32'(access_addr_o), 32'd0);
      chk("midrst_wdata", 32'(write_data_o),  32'd0);
      chk("midrst_writes", 32'(wr_addr_q.size() - wr0), 32'd3);
      for (int i = 0; i < 3; i++) ref_mem[i] = rbeats[i];
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;

      run_cmd("after_rst", 8, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
